// File: rtl/simon_arbiter.sv
// rtl/simon_arbiter.sv - round-robin arbiter sharing one simon core between two requesters
module simon_arbiter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic         clk_i,
    input  logic         res_i,

    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic         req0_ctrl_i,
    input  logic [255:0] req0_key_i,
    input  logic [127:0] req0_data_i,

    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic         req1_ctrl_i,
    input  logic [255:0] req1_key_i,
    input  logic [127:0] req1_data_i,

    output logic         rsp0_valid_o,
    input  logic         rsp0_ready_i,
    output logic [127:0] rsp0_data_o,
    output logic         rsp0_err_o,

    output logic         rsp1_valid_o,
    input  logic         rsp1_ready_i,
    output logic [127:0] rsp1_data_o,
    output logic         rsp1_err_o,

    output logic         core_start_o,
    output logic         core_ctrl_o,
    output logic [255:0] core_keys_o,
    output logic [127:0] core_in_o,
    input  logic [127:0] core_out_i,
    input  logic         core_done_i,
    output logic         core_abort_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic         ctrl_q, ctrl_d;
    logic [255:0] key_q, key_d;
    logic [127:0] in_q, in_d;
    logic [127:0] result_q, result_d;
    logic         err_q, err_d;

    logic         grant_any;
    logic         grant_id;
    logic         rsp_taken;

    // Pick a requester: a lone requester wins, contention alternates against last_grant
    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid_i;
        end
    end

    assign rsp_taken = owner_q ? rsp1_ready_i : rsp0_ready_i;

    // Next-state logic and handshake/strobe outputs of the job FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ctrl_d       = ctrl_q;
        key_d        = key_q;
        in_d         = in_q;
        result_d     = result_q;
        err_d        = err_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        core_start_o = 1'b0;
        core_abort_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Readys are held low while reset is asserted so no job is accepted and then lost
                req0_ready_o = ~res_i & grant_any & ~grant_id;
                req1_ready_o = ~res_i & grant_any & grant_id;
                if (grant_any) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    ctrl_d       = grant_id ? req1_ctrl_i : req0_ctrl_i;
                    key_d        = grant_id ? req1_key_i  : req0_key_i;
                    in_d         = grant_id ? req1_data_i : req0_data_i;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start_o = 1'b1;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last allowed cycle still counts as success
                if (core_done_i) begin
                    result_d = core_out_i;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    core_abort_o = 1'b1;
                    result_d     = '0;
                    err_d        = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_taken) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and job registers; reset drops any job in flight
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ctrl_q       <= 1'b0;
            key_q        <= '0;
            in_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ctrl_q       <= ctrl_d;
            key_q        <= key_d;
            in_q         <= in_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Only the owning requester sees a response; the other channel stays quiet
    always_comb begin
        rsp0_valid_o = (state_q == S_RESP) & ~owner_q;
        rsp1_valid_o = (state_q == S_RESP) & owner_q;
        rsp0_data_o  = rsp0_valid_o ? result_q : '0;
        rsp1_data_o  = rsp1_valid_o ? result_q : '0;
        rsp0_err_o   = rsp0_valid_o & err_q;
        rsp1_err_o   = rsp1_valid_o & err_q;
    end

    assign core_ctrl_o = ctrl_q;
    assign core_keys_o = key_q;
    assign core_in_o   = in_q;

endmodule

// File: tb/tb_simon_arbiter.sv
// tb/tb_simon_arbiter.sv - directed testbench for simon_arbiter
module tb_simon_arbiter;

    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         res;
    logic         req0_valid, req0_ctrl, req1_valid, req1_ctrl;
    logic [255:0] req0_key, req1_key;
    logic [127:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [127:0] rsp0_data, rsp1_data;
    logic         core_start, core_ctrl, core_abort, core_done;
    logic [255:0] core_keys;
    logic [127:0] core_in, core_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 5;
    int rem = -1;
    int start_cnt = 0;
    int start_cyc = 0;
    int abort_cnt = 0;
    int abort_cyc = 0;
    int two_ready = 0;

    logic [255:0] K1 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    logic [127:0] D1 = 128'h63736564207372656c6c657661727420;
    logic [255:0] K2 = 256'hdeadbeef_00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98;
    logic [127:0] D2 = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    logic [255:0] K3 = 256'h5555aaaa_5555aaaa_12345678_9abcdef0_0fedcba9_87654321_a5a5a5a5_5a5a5a5a;
    logic [127:0] D3 = 128'hcafef00d_baadf00d_01020304_05060708;

    simon_arbiter dut (
        .clk_i        (clk),
        .res_i        (res),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_ctrl_i  (req0_ctrl),
        .req0_key_i   (req0_key),
        .req0_data_i  (req0_data),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_ctrl_i  (req1_ctrl),
        .req1_key_i   (req1_key),
        .req1_data_i  (req1_data),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp0_data_o  (rsp0_data),
        .rsp0_err_o   (rsp0_err),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp1_data_o  (rsp1_data),
        .rsp1_err_o   (rsp1_err),
        .core_start_o (core_start),
        .core_ctrl_o  (core_ctrl),
        .core_keys_o  (core_keys),
        .core_in_o    (core_in),
        .core_out_i   (core_out),
        .core_done_i  (core_done),
        .core_abort_o (core_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] fexp(input logic [255:0] k, input logic [127:0] d, input logic c);
        return d ^ k[127:0] ^ k[255:128] ^ {128{c}};
    endfunction

    // Stand-in core: deterministic result, done pulse lat cycles after start (never if lat < 0)
    assign core_out = core_in ^ core_keys[127:0] ^ core_keys[255:128] ^ {128{core_ctrl}};

    always begin
        @(posedge clk);
        #2;
        core_done = 1'b0;
        if (core_start) begin
            rem = lat;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                core_done = 1'b1;
                rem = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (core_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (req0_ready && req1_ready) two_ready++;
    end

    task automatic submit(input int n, input logic [255:0] k, input logic [127:0] d, input logic c,
                          input string nm, output int acc_cyc, output int waited);
        bit got;
        got = 0;
        waited = 0;
        @(posedge clk);
        #1;
        if (n == 0) begin
            req0_valid = 1'b1; req0_key = k; req0_data = d; req0_ctrl = c;
        end else begin
            req1_valid = 1'b1; req1_key = k; req1_data = d; req1_ctrl = c;
        end
        for (int w = 0; w < 50 && !got; w++) begin
            @(negedge clk);
            waited++;
            got = (n == 0) ? req0_ready : req1_ready;
        end
        acc_cyc = cyc;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_ready: no ready after %0d cycles, required ready", nm, waited);
        end
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int bound, input logic [127:0] ed, input logic ee,
                            input string nm, output int vcyc);
        bit got;
        logic [127:0] ad;
        logic ae, ov;
        got = 0;
        for (int w = 0; w < bound && !got; w++) begin
            @(negedge clk);
            got = (n == 0) ? rsp0_valid : rsp1_valid;
        end
        vcyc = cyc;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_valid: rsp%0d_valid not seen within %0d cycles", nm, n, bound);
        end else begin
            ad = (n == 0) ? rsp0_data : rsp1_data;
            ae = (n == 0) ? rsp0_err : rsp1_err;
            ov = (n == 0) ? rsp1_valid : rsp0_valid;
            tests++;
            if (ad !== ed || ae !== ee) begin
                fails++;
                $display("FAIL %s_data: got data=%h err=%b, required data=%h err=%b", nm, ad, ae, ed, ee);
            end
            tests++;
            if (ov !== 1'b0) begin
                fails++;
                $display("FAIL %s_other: other rsp_valid=%b, required 0", nm, ov);
            end
            @(posedge clk);
            #1;
            if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
            @(negedge clk);
            ov = (n == 0) ? rsp0_valid : rsp1_valid;
            tests++;
            if (ov !== 1'b0) begin
                fails++;
                $display("FAIL %s_drop: rsp_valid=%b after take, required 0", nm, ov);
            end
        end
    endtask

    function automatic logic [905:0] all_outs();
        return {req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data,
                rsp1_err, core_start, core_ctrl, core_keys, core_in, core_abort};
    endfunction

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (all_outs() !== '0) begin
            fails++;
            $display("FAIL reset_outs: outputs=%h, required 0", all_outs());
        end
        @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        tests++;
        if (all_outs() !== '0) begin
            fails++;
            $display("FAIL reset_idle: outputs=%h, required 0", all_outs());
        end
    endtask

    task automatic test_contention();
        int v, g;
        bit got;
        lat = 5;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_key = K2; req0_data = D2; req0_ctrl = 1'b0;
        req1_valid = 1'b1; req1_key = K3; req1_data = D3; req1_ctrl = 1'b1;
        for (int j = 0; j < 4; j++) begin
            got = 0;
            g = -1;
            for (int w = 0; w < 50 && !got; w++) begin
                if (w > 0 || j == 0) @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1;
                    g = req1_ready ? 1 : 0;
                end
            end
            tests++;
            if (g != j % 2) begin
                fails++;
                $display("FAIL contention_grant%0d: granted %0d, required %0d", j, g, j % 2);
            end
            @(posedge clk);
            #1;
            if (j == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            if (j % 2 == 0) wait_rsp(0, 50, fexp(K2, D2, 1'b0), 1'b0, "contention_rsp0", v);
            else            wait_rsp(1, 50, fexp(K3, D3, 1'b1), 1'b0, "contention_rsp1", v);
        end
    endtask

    task automatic test_single();
        int t, w, v, s0;
        lat = 70;
        s0 = start_cnt;
        submit(0, K1, D1, 1'b1, "single", t, w);
        tests++;
        if (w != 1) begin
            fails++;
            $display("FAIL single_same_cycle: ready after %0d cycles, required 1", w);
        end
        wait_rsp(0, 200, fexp(K1, D1, 1'b1), 1'b0, "single_rsp", v);
        tests++;
        if (start_cnt != s0 + 1 || start_cyc != t + 1) begin
            fails++;
            $display("FAIL single_start: pulses=%0d at cycle %0d, required 1 at %0d", start_cnt - s0, start_cyc, t + 1);
        end
        tests++;
        if (v != t + 1 + 70 + 1) begin
            fails++;
            $display("FAIL single_latency: rsp at cycle %0d, required %0d", v, t + 72);
        end
    endtask

    task automatic test_stall();
        int t, w, v;
        bit bad;
        bit seen;
        lat = 5;
        submit(1, K3, D3, 1'b0, "stall", t, w);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = rsp1_valid;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_key = K1; req0_data = D2; req0_ctrl = 1'b1;
        bad = !seen;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp1_valid !== 1'b1 || rsp1_data !== fexp(K3, D3, 1'b0) || rsp1_err !== 1'b0 ||
                req0_ready !== 1'b0 || rsp0_valid !== 1'b0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL stall_hold: rsp1_valid=%b data=%h req0_ready=%b, required held 1/%h/0",
                     rsp1_valid, rsp1_data, req0_ready, fexp(K3, D3, 1'b0));
        end
        wait_rsp(1, 5, fexp(K3, D3, 1'b0), 1'b0, "stall_rsp1", v);
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_next_ready: req0_ready=%b after take, required 1", req0_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_rsp(0, 50, fexp(K1, D2, 1'b1), 1'b0, "stall_rsp0", v);
    endtask

    task automatic test_timeout();
        int t, w, v, a0;
        lat = -1;
        a0 = abort_cnt;
        submit(1, K2, D3, 1'b1, "timeout", t, w);
        wait_rsp(1, TO + 50, 128'h0, 1'b1, "timeout_rsp", v);
        tests++;
        if (abort_cnt != a0 + 1 || abort_cyc != start_cyc + TO) begin
            fails++;
            $display("FAIL timeout_abort: %0d pulses at cycle %0d, required 1 at %0d", abort_cnt - a0, abort_cyc, start_cyc + TO);
        end
        tests++;
        if (v != abort_cyc + 1) begin
            fails++;
            $display("FAIL timeout_rsp_cycle: rsp at %0d, required %0d", v, abort_cyc + 1);
        end
        lat = 5;
        submit(0, K3, D1, 1'b0, "after_timeout", t, w);
        tests++;
        if (w != 1) begin
            fails++;
            $display("FAIL after_timeout_accept: ready after %0d cycles, required 1", w);
        end
        wait_rsp(0, 50, fexp(K3, D1, 1'b0), 1'b0, "after_timeout_rsp", v);
    endtask

    task automatic test_done_at_timeout();
        int t, w, v, a0;
        lat = TO;
        a0 = abort_cnt;
        submit(0, K1, D3, 1'b1, "edge", t, w);
        wait_rsp(0, TO + 50, fexp(K1, D3, 1'b1), 1'b0, "edge_rsp", v);
        tests++;
        if (abort_cnt != a0) begin
            fails++;
            $display("FAIL edge_no_abort: %0d abort pulses, required 0", abort_cnt - a0);
        end
        tests++;
        if (v != start_cyc + TO + 1) begin
            fails++;
            $display("FAIL edge_rsp_cycle: rsp at %0d, required %0d", v, start_cyc + TO + 1);
        end
    endtask

    task automatic test_reset_mid();
        int t, w, v, s0;
        bit bad;
        lat = 30;
        submit(0, K2, D1, 1'b0, "mid", t, w);
        repeat (5) @(negedge clk);
        s0 = start_cnt;
        @(posedge clk);
        #1;
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        tests++;
        if (all_outs() !== '0) begin
            fails++;
            $display("FAIL mid_reset_outs: outputs=%h, required 0", all_outs());
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || core_start) bad = 1;
        end
        tests++;
        if (bad || start_cnt != s0) begin
            fails++;
            $display("FAIL mid_no_rsp: stray response or start (starts=%0d), required none", start_cnt - s0);
        end
        lat = 5;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_key = K3; req0_data = D2; req0_ctrl = 1'b1;
        req1_valid = 1'b1; req1_key = K1; req1_data = D1; req1_ctrl = 1'b0;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_first_grant: ready0=%b ready1=%b, required 1/0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(0, 50, fexp(K3, D2, 1'b1), 1'b0, "mid_rsp", v);
    endtask

    initial begin
        res = 1'b1;
        req0_valid = 1'b0; req0_ctrl = 1'b0; req0_key = '0; req0_data = '0;
        req1_valid = 1'b0; req1_ctrl = 1'b0; req1_key = '0; req1_data = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        core_done = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_stall();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        tests++;
        if (two_ready != 0) begin
            fails++;
            $display("FAIL one_ready: both readys high in %0d cycles, required 0", two_ready);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
